// File: rtl/pit_pkg.sv
// Shared constants for the programmable interval timer: register map, CTRL bit
// positions and the byte-lane write merge used by the register file.
package pit_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_CTRL   = 0;
  localparam int REG_PERIOD = 1;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_RLD   = 2;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0]   old_val,
    input logic [DATA_W-1:0]   new_val,
    input logic [DATA_W/8-1:0] be
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pit_counter.sv
// Down-counter with optional auto-reload; emits a registered one-cycle irq pulse
// on each terminal count while interrupts are enabled.
module pit_counter
  import pit_pkg::*;
#(
  parameter int CNT_W = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ie,
  input  logic             rld,
  input  logic [CNT_W-1:0] period,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             irq
);

  logic [CNT_W-1:0] count;
  logic             terminal;

  assign terminal = en && (count == CNT_W'(1));

  // A software load takes priority over both decrement and reload, but the
  // terminal event on the same edge still fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      irq   <= 1'b0;
    end else begin
      irq <= terminal && ie;
      if (load) begin
        count <= load_value;
      end else if (terminal) begin
        count <= rld ? period : '0;
      end else if (en && (count > CNT_W'(1))) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pit_top_level.sv
// PIT bus slave: CE decode, byte-enable CTRL/PERIOD registers, combinational
// read mux and acknowledges, driving the pit_counter core.
module pit_top_level
  import pit_pkg::*;
#(
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_NUM_REG    = 2
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      Bus2IP_Resetn,
  input  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
  input  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_RdCE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_WrCE,
  output logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
  output logic                      IP2Bus_RdAck,
  output logic                      IP2Bus_WrAck,
  output logic                      IP2Bus_Error,
  output logic                      IP_Interupt
);

  // CE vectors are MSB-first: the highest bit selects register 0.
  localparam int CE_CTRL   = C_NUM_REG - 1 - REG_CTRL;
  localparam int CE_PERIOD = C_NUM_REG - 1 - REG_PERIOD;

  logic [C_SLV_DWIDTH-1:0] ctrl;
  logic [C_SLV_DWIDTH-1:0] period;
  logic [C_SLV_DWIDTH-1:0] period_wr;
  logic                    wr_ctrl;
  logic                    wr_period;
  logic                    rd_ctrl;
  logic                    rd_period;

  assign wr_ctrl   = Bus2IP_WrCE[CE_CTRL];
  assign wr_period = Bus2IP_WrCE[CE_PERIOD];
  assign rd_ctrl   = Bus2IP_RdCE[CE_CTRL];
  assign rd_period = Bus2IP_RdCE[CE_PERIOD];

  assign period_wr = byte_merge(period, Bus2IP_Data, Bus2IP_BE);

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Resetn) begin
      ctrl   <= '0;
      period <= '0;
    end else begin
      if (wr_ctrl)   ctrl   <= byte_merge(ctrl, Bus2IP_Data, Bus2IP_BE);
      if (wr_period) period <= period_wr;
    end
  end

  assign IP2Bus_Data  = ({C_SLV_DWIDTH{rd_ctrl}}   & ctrl) |
                        ({C_SLV_DWIDTH{rd_period}} & period);
  assign IP2Bus_RdAck = |Bus2IP_RdCE;
  assign IP2Bus_WrAck = |Bus2IP_WrCE;
  assign IP2Bus_Error = 1'b0;

  // The counter sees pre-edge CTRL, so a CTRL write takes effect one edge later;
  // a PERIOD write reloads the count with the merged value on the same edge.
  pit_counter #(
    .CNT_W (C_SLV_DWIDTH)
  ) u_counter (
    .clk        (Bus2IP_Clk),
    .reset      (Bus2IP_Resetn),
    .en         (ctrl[CTRL_EN]),
    .ie         (ctrl[CTRL_IE]),
    .rld        (ctrl[CTRL_RLD]),
    .period     (period),
    .load       (wr_period),
    .load_value (period_wr),
    .irq        (IP_Interupt)
  );

endmodule

// File: tb/tb_pit_top_level.sv
// Bench for pit_top_level: directed and randomized register/timer scenarios
// checked against pulse schedules computed from the period arithmetic.
module tb_pit_top_level;

  logic        Bus2IP_Clk;
  logic        Bus2IP_Resetn;
  logic [31:0] Bus2IP_Data;
  logic [3:0]  Bus2IP_BE;
  logic [1:0]  Bus2IP_RdCE;
  logic [1:0]  Bus2IP_WrCE;
  logic [31:0] IP2Bus_Data;
  logic        IP2Bus_RdAck;
  logic        IP2Bus_WrAck;
  logic        IP2Bus_Error;
  logic        IP_Interupt;

  int n_cmp  = 0;
  int n_fail = 0;

  pit_top_level dut (
    .Bus2IP_Clk    (Bus2IP_Clk),
    .Bus2IP_Resetn (Bus2IP_Resetn),
    .Bus2IP_Data   (Bus2IP_Data),
    .Bus2IP_BE     (Bus2IP_BE),
    .Bus2IP_RdCE   (Bus2IP_RdCE),
    .Bus2IP_WrCE   (Bus2IP_WrCE),
    .IP2Bus_Data   (IP2Bus_Data),
    .IP2Bus_RdAck  (IP2Bus_RdAck),
    .IP2Bus_WrAck  (IP2Bus_WrAck),
    .IP2Bus_Error  (IP2Bus_Error),
    .IP_Interupt   (IP_Interupt)
  );

  initial Bus2IP_Clk = 1'b0;
  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Register 0 is CTRL, register 1 is PERIOD; returns the irq seen after the write edge.
  task automatic bus_write(input int reg_idx, input logic [31:0] d, input logic [3:0] be,
                           output logic irq_after);
    @(negedge Bus2IP_Clk);
    Bus2IP_WrCE = (reg_idx == 0) ? 2'b10 : 2'b01;
    Bus2IP_Data = d;
    Bus2IP_BE   = be;
    #1;
    chk("wrack", 32'(IP2Bus_WrAck), 32'd1);
    chk("error", 32'(IP2Bus_Error), 32'd0);
    @(posedge Bus2IP_Clk);
    #1;
    irq_after   = IP_Interupt;
    Bus2IP_WrCE = 2'b00;
    Bus2IP_BE   = 4'h0;
  endtask

  task automatic bus_read(input int reg_idx, output logic [31:0] d);
    @(negedge Bus2IP_Clk);
    Bus2IP_RdCE = (reg_idx == 0) ? 2'b10 : 2'b01;
    #1;
    d = IP2Bus_Data;
    chk("rdack", 32'(IP2Bus_RdAck), 32'd1);
    Bus2IP_RdCE = 2'b00;
  endtask

  // Expected pulses: edge n_per after the last write, then every n_per edges if periodic.
  task automatic collect(input string tag, input int ncyc, input int n_per, input bit periodic);
    int obs_q[$];
    int exp_q[$];
    if (n_per > 0) begin
      for (int k = n_per; k <= ncyc; k += n_per) begin
        exp_q.push_back(k);
        if (!periodic) break;
      end
    end
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge Bus2IP_Clk);
      #1;
      if (IP_Interupt === 1'b1) obs_q.push_back(i);
    end
    chk({tag, "_npulses"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      chk({tag, "_pulse_at"}, (k < obs_q.size()) ? 32'(obs_q[k]) : 32'hFFFF_FFFF, 32'(exp_q[k]));
    end
  endtask

  initial begin
    logic        irq_w;
    logic [31:0] rd;
    logic [31:0] d;
    logic [31:0] exp_v;
    logic [3:0]  be;
    int          n;
    int          m;
    logic [2:0]  c;

    Bus2IP_Resetn = 1'b1;
    Bus2IP_Data   = '0;
    Bus2IP_BE     = '0;
    Bus2IP_RdCE   = 2'b01;
    Bus2IP_WrCE   = 2'b00;

    // Reset held for two edges with a PERIOD read active
    for (int i = 0; i < 2; i++) begin
      @(posedge Bus2IP_Clk);
      #1;
      chk("rst_irq", 32'(IP_Interupt), 32'd0);
      chk("rst_data", IP2Bus_Data, 32'd0);
      chk("rst_rdack", 32'(IP2Bus_RdAck), 32'd1);
    end
    @(negedge Bus2IP_Clk);
    Bus2IP_Resetn = 1'b0;
    Bus2IP_RdCE   = 2'b00;
    bus_read(0, rd); chk("rst_ctrl", rd, 32'd0);
    bus_read(1, rd); chk("rst_period", rd, 32'd0);

    // Byte enables
    bus_write(1, 32'hAABBCCDD, 4'b0101, irq_w);
    bus_read(1, rd); chk("be_period", rd, 32'h00BB00DD);
    for (int t = 0; t < 4; t++) begin
      bus_write(1, 32'h0, 4'hF, irq_w);
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      exp_v = 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) exp_v += d & (32'hFF << (8 * b));
      bus_write(1, d, be, irq_w);
      bus_read(1, rd); chk("be_rand", rd, exp_v);
    end
    bus_write(0, 32'h12345678, 4'b1000, irq_w);
    bus_read(0, rd); chk("be_ctrl", rd, 32'h12000000);
    bus_write(0, 32'h0, 4'hF, irq_w);

    // Periodic, PERIOD=5
    bus_write(1, 32'd5, 4'hF, irq_w);
    bus_write(0, 32'h7, 4'hF, irq_w);
    collect("periodic5", 22, 5, 1'b1);

    // Single shot, then rearm by rewriting PERIOD
    bus_write(0, 32'h0, 4'hF, irq_w);
    bus_write(1, 32'd3, 4'hF, irq_w);
    bus_write(0, 32'h3, 4'hF, irq_w);
    collect("oneshot", 23, 3, 1'b0);
    bus_write(1, 32'd3, 4'hF, irq_w);
    collect("rearm", 10, 3, 1'b0);

    // Masking: IE=0, then IE=1 with a restart, then PERIOD=0
    bus_write(0, 32'h0, 4'hF, irq_w);
    bus_write(1, 32'd4, 4'hF, irq_w);
    bus_write(0, 32'h5, 4'hF, irq_w);
    collect("masked", 12, 0, 1'b0);
    bus_write(0, 32'h7, 4'hF, irq_w);
    bus_write(1, 32'd4, 4'hF, irq_w);
    collect("unmasked", 13, 4, 1'b1);
    bus_write(1, 32'd0, 4'hF, irq_w);
    collect("period0", 20, 0, 1'b0);

    // PERIOD write exactly on a terminal edge
    bus_write(0, 32'h0, 4'hF, irq_w);
    bus_write(1, 32'd5, 4'hF, irq_w);
    bus_write(0, 32'h7, 4'hF, irq_w);
    collect("pre_coll", 4, 0, 1'b0);
    m = $urandom_range(3, 8);
    bus_write(1, 32'(m), 4'hF, irq_w);
    chk("coll_irq", 32'(irq_w), 32'd1);
    collect("post_coll", 3 * m, m, 1'b1);

    // Randomized period and control word
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(0, 9);
      c = 3'($urandom_range(0, 7));
      bus_write(0, 32'h0, 4'hF, irq_w);
      bus_write(1, 32'(n), 4'hF, irq_w);
      bus_write(0, 32'(c), 4'hF, irq_w);
      collect("rand", 3 * n + 4, (c[0] && c[1]) ? n : 0, c[2]);
    end

    // Reset mid-count, with a concurrent PERIOD write that must be ignored
    bus_write(0, 32'h0, 4'hF, irq_w);
    bus_write(1, 32'd6, 4'hF, irq_w);
    bus_write(0, 32'h7, 4'hF, irq_w);
    collect("pre_rst", 3, 0, 1'b0);
    @(negedge Bus2IP_Clk);
    Bus2IP_Resetn = 1'b1;
    Bus2IP_WrCE   = 2'b01;
    Bus2IP_Data   = 32'd9;
    Bus2IP_BE     = 4'hF;
    @(posedge Bus2IP_Clk);
    #1;
    chk("midrst_irq", 32'(IP_Interupt), 32'd0);
    @(negedge Bus2IP_Clk);
    Bus2IP_Resetn = 1'b0;
    Bus2IP_WrCE   = 2'b00;
    Bus2IP_BE     = 4'h0;
    collect("post_rst", 12, 0, 1'b0);
    bus_read(0, rd); chk("midrst_ctrl", rd, 32'd0);
    bus_read(1, rd); chk("midrst_period", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pit_top_level.md
# pit_top_level

Programmable interval timer (PIT) peripheral with a two-register IPIF-style bus slave. Software writes a 32-bit period and a control word. A down-counter then produces a periodic, or single-shot, one-cycle interrupt pulse every `period` clock cycles. The block sits behind the bus-attachment wrapper and drives one interrupt line to the system interrupt controller.

## Interface
- `C_SLV_DWIDTH`, 32: bus data width; also the counter and period width.
- `C_NUM_REG`, 2: number of software registers. Fixed at 2.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `Bus2IP_Clk` in 1: sole clock. All state updates on the rising edge.
- `Bus2IP_Resetn` in 1: reset. Synchronous and active-high despite the suffix; 1 resets all state.
- `Bus2IP_Data` in 32: write data.
- `Bus2IP_BE` in 4: byte enables for writes. Bit i enables data[8i+7:8i].
- `Bus2IP_RdCE` in 2: read chip enables, one-hot. Bit 1 selects reg0 (CTRL); bit 0 selects reg1 (PERIOD).
- `Bus2IP_WrCE` in 2: write chip enables, one-hot, same mapping as `Bus2IP_RdCE`.
- `IP2Bus_Data` out 32: read data.
- `IP2Bus_RdAck` out 1: read acknowledge.
- `IP2Bus_WrAck` out 1: write acknowledge.
- `IP2Bus_Error` out 1: error. Tied to 0.
- `IP_Interupt` out 1: interrupt pulse. The name is spelled exactly this way.

## Operation
- **CTRL register (reg0)**
  - bit0 `EN`: counter runs.
  - bit1 `IE`: interrupt enable.
  - bit2 `RLD`: auto-reload.
  - Bits 31:3 are stored but have no function.
- **PERIOD register (reg1)**: 32-bit reload value.
- **Writes**
  - For each byte with `Bus2IP_BE[i]=1`, the selected register takes that byte at the edge.
  - A write to PERIOD also loads `count` with the newly written PERIOD value at the same edge.
- **Reads**: `IP2Bus_Data` = selected register when one `RdCE` bit is set, else 0. `count` is not software-visible.
- **Counter**, evaluated on each edge using pre-edge register values:
  - If `EN=1`, `count>1`: count decrements by 1.
  - If `EN=1`, `count==1` (terminal): count becomes PERIOD if `RLD=1`, else 0. Interrupt register is set to `IE`.
  - If `count==0` or `EN=0`: count holds and no event occurs.
  - Result: PERIOD=N with auto-reload gives one event every N cycles. PERIOD=0 gives no events.
- **Single-shot mode** (`RLD=0`): the counter stops at 0 after one event. Writing PERIOD rearms it.
- **Interrupt**: `IP_Interupt` is registered and high for exactly one cycle per event. It is 0 on every other edge.
- **Simultaneous events**
  - PERIOD write on a terminal edge: the event still fires, and `count` takes the written value (the write wins over the reload).
  - CTRL write on a terminal edge: the event uses the old CTRL; the new CTRL applies from the next edge.
- **Multiple CE bits set** (illegal): a write updates every selected register; read data is the OR of the selected registers.

## Timing
- **Reset** (`Bus2IP_Resetn=1` at an edge): CTRL=0, PERIOD=0, count=0, `IP_Interupt`=0.
  - Reset overrides any concurrent write.
  - Reset mid-count aborts the count, and no interrupt is produced.
- **Acknowledges**, combinational and zero-latency:
  - `IP2Bus_WrAck` = OR(`WrCE`); `IP2Bus_RdAck` = OR(`RdCE`).
  - `IP2Bus_Data` is combinational from the registers.
  - Acks follow the CE inputs even during reset.
- **Write to interrupt latency**: with PERIOD=N already loaded, CTRL=`EN`|`IE` written at edge E0 gives first `IP_Interupt` high during the cycle after edge E0+N.

## Structure
- Shared package `pit_pkg`:
  - register indices `REG_CTRL=0`, `REG_PERIOD=1`;
  - CTRL bit positions `CTRL_EN=0`, `CTRL_IE=1`, `CTRL_RLD=2`;
  - data width constant 32.
- Sub-module `pit_counter`:
  - inputs: clk, reset, en, ie, rld, period, load, load_value;
  - output: irq pulse.
- The top level holds the bus decode, byte-enable register file and read mux.

## Test plan
- **Reset**: hold `Bus2IP_Resetn=1` for 2 cycles with `RdCE=2'b01`.
  - During reset: `IP_Interupt`=0, `IP2Bus_Data`=0, `RdAck`=1.
  - After release: reads of CTRL and PERIOD return 0x0.
- **Byte enables**: write PERIOD=0xAABBCCDD with BE=4'b0101, then read.
  - Read returns 0x00BB00DD and `WrAck` is 1 in the write cycle.
  - `IP2Bus_Error` is 0 throughout.
- **Periodic**: PERIOD=5, CTRL=0x7.
  - `IP_Interupt` pulses 1 cycle wide, every 5 cycles; the first pulse follows the enable edge by 5 edges.
  - Check 4 pulses.
- **Single-shot**: PERIOD=3, CTRL=0x3.
  - Exactly one pulse, then silence for 20 cycles.
  - Rewrite PERIOD=3 and observe one more pulse 3 edges later.
- **Masking**
  - PERIOD=4, CTRL=0x5 (`IE`=0): no pulses. Setting CTRL=0x7 gives pulses every 4 cycles.
  - PERIOD=0 with CTRL=0x7: no pulses.
- **Collisions**
  - PERIOD write on a terminal edge: the pulse still occurs, and the next interval equals the new period.
  - Reset asserted mid-count: no pulse, and registers return to 0.
